mem_arbiter: RTL and testbench

Parametrised N-master arbiter in front of the single-port on-chip RAM. It generalises the fixed two-way IO/core select into NUM_MASTERS requesters. Each requester uses a req/gnt handshake, and the arbiter offers a choice of fixed-priority or round-robin arbitration plus a forced-owner override. Read data returns through a tagged pipeline that matches the RAM read latency. It sits between the IO front end, the execution core and any future bus masters, and the RAM instance.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// N-master req/gnt arbiter in front of a single-port RAM with fixed-priority,
// round-robin and forced-owner modes; read data returns via a tagged pipeline.

module mem_arbiter_lane #(
    parameter int IDX   = 0,
    parameter int PTR_W = 1
) (
    input  logic             req,
    input  logic             force_en,
    input  logic [2:0]       force_id,
    input  logic             win_vld,
    input  logic [PTR_W-1:0] win_id,
    input  logic             rsp_vld,
    input  logic [PTR_W-1:0] rsp_id,
    output logic             elig,
    output logic             gnt,
    output logic             rvalid
);
    // An out-of-range force_id matches no lane, so nothing is eligible.
    assign elig   = req && (!force_en || (force_id == 3'(IDX)));
    assign gnt    = win_vld && (win_id == PTR_W'(IDX));
    assign rvalid = rsp_vld && (rsp_id == PTR_W'(IDX));
endmodule

module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int RD_LATENCY  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              arb_mode,
    input  logic                              force_en,
    input  logic [2:0]                        force_id,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [ADDR_WIDTH-1:0]             ram_address,
    output logic [DATA_WIDTH-1:0]             ram_data,
    output logic                              ram_wren,
    input  logic [DATA_WIDTH-1:0]             ram_q,
    output logic                              busy
);
    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef struct packed {
        logic             vld;
        logic [PTR_W-1:0] id;
    } rd_tag_t;

    logic [NUM_MASTERS-1:0] elig;
    logic [PTR_W-1:0]       rr_ptr;
    logic                   win_vld;
    logic [PTR_W-1:0]       win_id;
    logic [ADDR_WIDTH-1:0]  sel_addr, hold_addr;
    logic [DATA_WIDTH-1:0]  sel_data, hold_data;
    logic                   sel_we;
    rd_tag_t                rd_pipe [RD_LATENCY];
    rd_tag_t                push, rsp;
    logic                   rsp_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
            mem_arbiter_lane #(.IDX(gi), .PTR_W(PTR_W)) u_lane (
                .req      (m_req[gi]),
                .force_en (force_en),
                .force_id (force_id),
                .win_vld  (win_vld),
                .win_id   (win_id),
                .rsp_vld  (rsp_vld),
                .rsp_id   (rsp.id),
                .elig     (elig[gi]),
                .gnt      (m_gnt[gi]),
                .rvalid   (m_rvalid[gi])
            );
        end
    endgenerate

    // Fixed priority is round-robin with the search pinned to index 0.
    always_comb begin : arb
        logic [PTR_W-1:0] start;
        logic [PTR_W:0]   idx;
        start   = arb_mode ? rr_ptr : '0;
        idx     = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = {1'b0, start} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_MASTERS))
                idx = idx - (PTR_W+1)'(NUM_MASTERS);
            if (!win_vld && reset && elig[idx[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_id  = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_gnt[i]) begin
                sel_addr = sel_addr | m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = sel_data | m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we   = sel_we | m_we[i];
            end
        end
    end

    // Idle cycles replay the last granted address/data to keep the RAM bus quiet.
    assign ram_address = win_vld ? sel_addr : hold_addr;
    assign ram_data    = win_vld ? sel_data : hold_data;
    assign ram_wren    = win_vld & sel_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else if (win_vld) begin
            rr_ptr    <= (win_id == PTR_W'(NUM_MASTERS-1)) ? '0 : win_id + 1'b1;
            hold_addr <= sel_addr;
            hold_data <= sel_data;
        end
    end

    assign push.vld = win_vld & ~sel_we;
    assign push.id  = win_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < RD_LATENCY; s++) rd_pipe[s] <= '0;
        end else begin
            rd_pipe[0] <= push;
            for (int s = 1; s < RD_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
        end
    end

    assign rsp     = rd_pipe[RD_LATENCY-1];
    assign rsp_vld = rsp.vld & reset;
    assign m_rdata = reset ? ram_q : '0;

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < RD_LATENCY; s++) busy = busy | rd_pipe[s].vld;
        busy = busy & reset;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter (4 masters, read latency 2)
// against a transaction-level model of grants, RAM contents and read returns.

module tb_mem_arbiter;
    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arb_mode = 1'b0;
    logic            force_en = 1'b0;
    logic [2:0]      force_id = 3'd0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_gnt, m_rvalid;
    logic [DW-1:0]   m_rdata, ram_data, ram_q;
    logic [AW-1:0]   ram_address;
    logic            ram_wren, busy;

    mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .arb_mode(arb_mode), .force_en(force_en),
        .force_id(force_id), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM environment: 256 words preloaded with 16'hA000+addr, LAT-cycle read.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] q1, q2;
    assign ram_q = q2;
    initial begin
        for (int a = 0; a < 256; a++) ram_mem[a] = 16'hA000 + 16'(a);
        q1 = '0;
        q2 = '0;
        forever begin
            @(posedge clk);
            q2 = q1;
            q1 = ram_mem[ram_address[7:0]];
            if (ram_wren) ram_mem[ram_address[7:0]] = ram_data;
        end
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pend [$];
    logic [DW-1:0] exp_mem [256];
    int            rr = 0;
    int            cyc = 0;
    int            cur_w = -1;
    logic [AW-1:0] hold_a = '0;
    logic [DW-1:0] hold_d = '0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [N-1:0]  obs_gnt, obs_rv;
    logic [DW-1:0] obs_rdata;
    logic          obs_busy, obs_wren;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_m(input int i, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[i] = req;
        m_we[i]  = we;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    // Model: pick the winner from the rules, compare every output of this cycle.
    task automatic check_cycle();
        logic [N-1:0]  exp_gnt, exp_rv;
        logic [DW-1:0] exp_rd;
        int            start, idx;
        exp_gnt = '0;
        exp_rv  = '0;
        exp_rd  = '0;
        cur_w   = -1;
        if (reset) begin
            start = arb_mode ? rr : 0;
            for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (cur_w < 0 && m_req[idx] && (!force_en || int'(force_id) == idx))
                    cur_w = idx;
            end
        end
        if (cur_w >= 0) exp_gnt[2'(cur_w)] = 1'b1;
        obs_gnt = m_gnt; obs_rv = m_rvalid; obs_rdata = m_rdata;
        obs_busy = busy; obs_wren = ram_wren;
        chk("gnt", 32'(m_gnt), 32'(exp_gnt));
        if (cur_w >= 0) begin
            chk("ram_address", 32'(ram_address), 32'(m_addr[cur_w*AW +: AW]));
            chk("ram_data", 32'(ram_data), 32'(m_wdata[cur_w*DW +: DW]));
            chk("ram_wren", 32'(ram_wren), 32'(m_we[cur_w]));
        end else begin
            chk("ram_wren_idle", 32'(ram_wren), 32'd0);
            if (reset) begin
                chk("ram_address_hold", 32'(ram_address), 32'(hold_a));
                chk("ram_data_hold", 32'(ram_data), 32'(hold_d));
            end
        end
        if (reset) begin
            foreach (pend[j]) if (pend[j].due == cyc) begin
                exp_rv[2'(pend[j].id)] = 1'b1;
                exp_rd = pend[j].data;
            end
        end
        chk("rvalid", 32'(m_rvalid), 32'(exp_rv));
        if (exp_rv != 0 || !reset) chk("rdata", 32'(m_rdata), 32'(exp_rd));
        chk("busy", 32'(busy), 32'(reset && pend.size() > 0));
    endtask

    task automatic update();
        int a;
        if (!reset) begin
            rr = 0;
            pend.delete();
            hold_a = '0;
            hold_d = '0;
        end else begin
            for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].due <= cyc) pend.delete(j);
            if (cur_w >= 0) begin
                rr = (cur_w + 1) % N;
                hold_a = m_addr[cur_w*AW +: AW];
                hold_d = m_wdata[cur_w*DW +: DW];
                a = int'(hold_a[7:0]);
                if (m_we[cur_w]) exp_mem[a] = hold_d;
                else pend.push_back('{cyc + LAT, cur_w, exp_mem[a]});
            end
        end
        cyc++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update();
        #1;
    endtask

    initial begin
        int g1, g3;
        for (int a = 0; a < 256; a++) exp_mem[a] = 16'hA000 + 16'(a);

        // Reset held with every master requesting reads of address i.
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, AW'(i), '0);
        repeat (3) run_cycle();
        chk("rst_gnt", 32'(obs_gnt), 32'd0);
        chk("rst_wren", 32'(obs_wren), 32'd0);
        chk("rst_rvalid", 32'(obs_rv), 32'd0);
        reset = 1'b1;
        run_cycle();
        chk("rst_first_gnt", 32'(obs_gnt), 32'b0001);

        // Fixed priority: masters 1 and 3 requesting.
        m_req = 4'b1010;
        g1 = 0; g3 = 0;
        repeat (3) begin
            run_cycle();
            g1 += int'(obs_gnt[1]);
            g3 += int'(obs_gnt[3]);
        end
        chk("fp_m1_grants", 32'(g1), 32'd3);
        chk("fp_m3_grants", 32'(g3), 32'd0);

        // Round-robin from a fresh pointer: all four read continuously.
        m_req = '0;
        reset = 1'b0;
        run_cycle();
        reset = 1'b1;
        arb_mode = 1'b1;
        m_req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            chk("rr_order", 32'(obs_gnt), 32'(4'b0001 << (c % 4)));
            if (c >= LAT) begin
                chk("rr_rvalid", 32'(obs_rv), 32'(4'b0001 << ((c - LAT) % 4)));
                chk("rr_rdata", 32'(obs_rdata), 32'(16'hA000 + 16'((c - LAT) % 4)));
            end
        end
        m_req = '0;
        repeat (3) run_cycle();

        // Write then read the same address from another master.
        arb_mode = 1'b0;
        set_m(0, 1'b1, 1'b1, 16'd5, 16'h1234);
        run_cycle();
        set_m(0, 1'b0, 1'b0, 16'd5, 16'h1234);
        set_m(1, 1'b1, 1'b0, 16'd5, 16'h0000);
        run_cycle();
        chk("war_no_rv", 32'(obs_rv), 32'd0);
        m_req = '0;
        run_cycle();
        chk("war_no_rv0", 32'(obs_rv), 32'd0);
        run_cycle();
        chk("war_rvalid", 32'(obs_rv), 32'b0010);
        chk("war_rdata", 32'(obs_rdata), 32'h1234);

        // Force override, then an out-of-range owner.
        m_req = 4'b1111;
        force_en = 1'b1;
        force_id = 3'd1;
        repeat (2) begin
            run_cycle();
            chk("force_gnt", 32'(obs_gnt), 32'b0010);
        end
        force_id = 3'd6;
        repeat (2) begin
            run_cycle();
            chk("force_oor_gnt", 32'(obs_gnt), 32'd0);
            chk("force_oor_wren", 32'(obs_wren), 32'd0);
        end
        force_en = 1'b0;
        m_req = '0;
        repeat (3) run_cycle();

        // Reset while a read is in flight.
        set_m(2, 1'b1, 1'b0, 16'd9, '0);
        run_cycle();
        chk("mid_gnt", 32'(obs_gnt), 32'b0100);
        m_req = '0;
        reset = 1'b0;
        run_cycle();
        chk("mid_rst_rv", 32'(obs_rv), 32'd0);
        reset = 1'b1;
        run_cycle();
        chk("mid_after_rv", 32'(obs_rv), 32'd0);
        chk("mid_after_busy", 32'(obs_busy), 32'd0);

        // Randomized traffic with occasional resets, mode and force changes.
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) != 0);
            arb_mode = 1'($urandom_range(0, 1));
            force_en = ($urandom_range(0, 7) == 0);
            force_id = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++)
                set_m(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 15)), DW'($urandom));
            run_cycle();
        end
        reset = 1'b1;
        m_req = '0;
        repeat (4) run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
